// File: rtl/mdu_pkg.sv
// Shared constants, encodings and operation context for the multiply/divide unit.
package mdu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ACC_W    = 2 * XLEN + 1;
  localparam int unsigned MDU_ITER = 32;
  localparam int unsigned CNT_W    = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } state_e;

  // Per-operation information captured at launch and consumed at FINISH
  typedef struct packed {
    logic            is_div;
    logic            neg_res;
    logic            neg_rem;
    logic            div_zero;
    logic [XLEN-1:0] a_raw;
  } mdu_ctx_t;

  // Magnitude of x when treated as signed; 0x8000_0000 maps to itself as unsigned
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? XLEN'(-x) : x;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the datapath: shift-add for multiply, restoring shift-subtract for divide.
module mdu_step
  import mdu_pkg::*;
(
  input  logic             is_div,
  input  logic [ACC_W-1:0] acc,
  input  logic [XLEN-1:0]  opnd,
  output logic [ACC_W-1:0] acc_next_c
);

  logic [XLEN:0]    sum;
  logic [XLEN:0]    rem;
  logic [XLEN:0]    diff;
  logic [ACC_W-1:0] sh;

  // Upper half accumulates / holds the partial remainder; lower half is multiplier / quotient
  always_comb begin
    sum  = acc[ACC_W-1:XLEN] + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    sh   = {acc[ACC_W-2:0], 1'b0};
    rem  = sh[ACC_W-1:XLEN];
    diff = rem - {1'b0, opnd};
    if (is_div) begin
      acc_next_c = (rem >= {1'b0, opnd}) ? {diff, sh[XLEN-1:1], 1'b1} : sh;
    end else begin
      acc_next_c = {1'b0, sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MIPS multiply/divide unit owning the HI/LO register pair.
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            hi_wen,
  input  logic            lo_wen,
  input  logic [XLEN-1:0] mt_data,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next_c;
  logic [XLEN-1:0]  opnd;
  mdu_ctx_t         ctx;

  logic             op_div;
  logic             op_sgn;
  logic [XLEN-1:0]  a_abs;
  logic [XLEN-1:0]  b_abs;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  hi_fin;
  logic [XLEN-1:0]  lo_fin;

  mdu_step u_step (
    .is_div     (ctx.is_div),
    .acc        (acc),
    .opnd       (opnd),
    .acc_next_c (acc_next_c)
  );

  // Operand magnitudes for launch
  always_comb begin
    op_div = op[1];
    op_sgn = ~op[0];
    a_abs  = abs_val(src_a, op_sgn);
    b_abs  = abs_val(src_b, op_sgn);
  end

  // Sign correction and divide-by-zero override of the final accumulator
  always_comb begin
    prod = ctx.neg_res ? (2*XLEN)'(-acc[2*XLEN-1:0]) : acc[2*XLEN-1:0];
    quo  = ctx.neg_res ? XLEN'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem  = ctx.neg_rem ? XLEN'(-acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
    if (!ctx.is_div) begin
      hi_fin = prod[2*XLEN-1:XLEN];
      lo_fin = prod[XLEN-1:0];
    end else if (ctx.div_zero) begin
      hi_fin = ctx.a_raw;
      lo_fin = {XLEN{1'b1}};
    end else begin
      hi_fin = rem;
      lo_fin = quo;
    end
  end

  // Control FSM, iteration state and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      ctx   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ctx.is_div   <= op_div;
            ctx.neg_res  <= op_sgn & (src_a[XLEN-1] ^ src_b[XLEN-1]);
            ctx.neg_rem  <= op_sgn & src_a[XLEN-1];
            ctx.div_zero <= (src_b == '0);
            ctx.a_raw    <= src_a;
            opnd         <= op_div ? b_abs : a_abs;
            acc          <= {{(XLEN+1){1'b0}}, (op_div ? a_abs : b_abs)};
            cnt          <= '0;
            busy         <= 1'b1;
            state        <= CALC;
          end else begin
            if (hi_wen) hi <= mt_data;
            if (lo_wen) lo <= mt_data;
          end
        end
        CALC: begin
          acc <= acc_next_c;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(MDU_ITER - 1)) state <= FINISH;
        end
        FINISH: begin
          hi    <= hi_fin;
          lo    <= lo_fin;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
